// File: rtl/ovl_seq_gen_pkg.sv
// Shared types and constants for the OVL cycle-sequence stimulus generator.
// Contents:
//   gen_state_e - burst FSM state (idle, inter-start gap, drain)
//   NUM_CKS_DEF - default sequence length; STG_W / MSB are derived from it.
//                 Parameterised modules derive their own copies from NUM_CKS.
package ovl_seq_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StDrain
  } gen_state_e;

  localparam int unsigned NUM_CKS_DEF = 3;
  localparam int unsigned STG_W       = $clog2(NUM_CKS_DEF);
  localparam int unsigned MSB         = NUM_CKS_DEF - 1;

endpackage

// File: rtl/ovl_cycle_sequence_gen_if.sv
// Request/response bundle of the cycle-sequence generator.
//   start, burst_len, gap, fault_en, fault_seq, fault_stage, stall : burst control (to generator)
//   event_sequence, busy, done, seq_count                          : generator outputs
// Modports: master = bench/harness side, slave = generator side.
interface ovl_cycle_sequence_gen_if #(
  parameter int unsigned NUM_CKS = 3,
  parameter int unsigned CNT_W   = 8
) ();

  logic                       start;
  logic [CNT_W-1:0]           burst_len;
  logic [CNT_W-1:0]           gap;
  logic                       fault_en;
  logic [CNT_W-1:0]           fault_seq;
  logic [$clog2(NUM_CKS)-1:0] fault_stage;
  logic                       stall;
  logic [NUM_CKS-1:0]         event_sequence;
  logic                       busy;
  logic                       done;
  logic [CNT_W-1:0]           seq_count;

  modport master (
    output start, burst_len, gap, fault_en, fault_seq, fault_stage, stall,
    input  event_sequence, busy, done, seq_count
  );

  modport slave (
    input  start, burst_len, gap, fault_en, fault_seq, fault_stage, stall,
    output event_sequence, busy, done, seq_count
  );

endinterface

// File: rtl/ovl_seq_token_shifter.sv
// Token shifter: one token per in-flight sequence walks from bit NUM_CKS-1 down to bit 0.
// A parallel marker register tracks the faulted sequence; its bit is cleared from the
// output only at the selected stage.
//   clk, reset     : clock, async active-high reset
//   stall          : freeze all state
//   issue          : start a new sequence this cycle
//   fault_hit      : the sequence issued this cycle is the faulted one
//   fault_stage    : stage whose bit is suppressed for the faulted sequence
//   tok            : raw token register (for FSM drain / no-pipe decisions)
//   event_sequence : registered, masked token vector (one cycle behind tok)
module ovl_seq_token_shifter #(
  parameter int unsigned NUM_CKS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       issue,
  input  logic                       fault_hit,
  input  logic [$clog2(NUM_CKS)-1:0] fault_stage,
  output logic [NUM_CKS-1:0]         tok,
  output logic [NUM_CKS-1:0]         event_sequence
);

  localparam int unsigned Msb = NUM_CKS - 1;

  logic [NUM_CKS-1:0] tok_q;
  logic [NUM_CKS-1:0] fmask_q;
  logic [NUM_CKS-1:0] evs_q;
  logic [NUM_CKS-1:0] stage_sel;

  // Stage s lives at bit Msb-s.
  always_comb begin
    stage_sel = '0;
    for (int b = 0; b < NUM_CKS; b++) begin
      if (int'(fault_stage) + b == int'(Msb)) stage_sel[b] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_q   <= '0;
      fmask_q <= '0;
      evs_q   <= '0;
    end else if (!stall) begin
      tok_q   <= (tok_q >> 1) | {issue, {Msb{1'b0}}};
      fmask_q <= (fmask_q >> 1) | {fault_hit, {Msb{1'b0}}};
      evs_q   <= tok_q & ~(fmask_q & stage_sel);
    end
  end

  assign tok            = tok_q;
  assign event_sequence = evs_q;

endmodule

// File: rtl/ovl_cycle_sequence_gen.sv
// Burst generator of well-formed (or single-stage-faulted) event sequences for an OVL
// cycle-sequence checker. Owns the burst FSM and counters; tokens live in the shifter.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of ovl_cycle_sequence_gen_if (controls in, event vector/status out)
// Parameters: NUM_CKS (sequence length), CNT_W (counter width), PIPELINED (overlap allowed).
module ovl_cycle_sequence_gen
  import ovl_seq_gen_pkg::*;
#(
  parameter int unsigned NUM_CKS   = 3,
  parameter int unsigned CNT_W     = 8,
  parameter bit          PIPELINED = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  ovl_cycle_sequence_gen_if.slave  bus
);

  localparam int unsigned StgW = $clog2(NUM_CKS);

  gen_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // gap cycles elapsed since last issue
  logic [CNT_W-1:0]   idx_q, idx_d;        // sequences issued in this burst
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   fseq_q, fseq_d;
  logic               fen_q, fen_d;
  logic [StgW-1:0]    fstage_q, fstage_d;
  logic [CNT_W-1:0]   seq_count_q, seq_count_d;
  logic               done_q, done_d;
  logic               issue;
  logic               fault_hit;
  logic [NUM_CKS-1:0] tok;
  logic [NUM_CKS-1:0] evs;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    gap_d       = gap_q;
    fseq_d      = fseq_q;
    fen_d       = fen_q;
    fstage_d    = fstage_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    fault_hit   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // Sequence 0 issues in the accept cycle, so its fault test uses the live inputs.
          issue     = 1'b1;
          fault_hit = bus.fault_en && (bus.fault_seq == '0);
          len_d     = (bus.burst_len == '0) ? CNT_W'(1) : bus.burst_len;
          gap_d     = bus.gap;
          fen_d     = bus.fault_en;
          fseq_d    = bus.fault_seq;
          fstage_d  = bus.fault_stage;
          idx_d     = CNT_W'(1);
          cnt_d     = '0;
          state_d   = (bus.burst_len <= CNT_W'(1)) ? StDrain : StGap;
        end
      end
      StGap: begin
        if (cnt_q != gap_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!PIPELINED && ((tok >> 1) != '0)) begin
          // No-pipe: hold until the previous token is leaving bit 0, so starts are
          // at least NUM_CKS cycles apart and never overlap.
          cnt_d = cnt_q;
        end else begin
          issue     = 1'b1;
          fault_hit = fen_q && (fseq_q == idx_q);
          idx_d     = idx_q + 1'b1;
          cnt_d     = '0;
          if (idx_q + 1'b1 == len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (tok == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    seq_count_d = seq_count_q + CNT_W'(issue);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      fseq_q      <= '0;
      fen_q       <= 1'b0;
      fstage_q    <= '0;
      seq_count_q <= '0;
      done_q      <= 1'b0;
    end else if (!bus.stall) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      fseq_q      <= fseq_d;
      fen_q       <= fen_d;
      fstage_q    <= fstage_d;
      seq_count_q <= seq_count_d;
      done_q      <= done_d;
    end
  end

  ovl_seq_token_shifter #(
    .NUM_CKS(NUM_CKS)
  ) u_shifter (
    .clk           (clk),
    .reset         (reset),
    .stall         (bus.stall),
    .issue         (issue),
    .fault_hit     (fault_hit),
    .fault_stage   (fstage_q),
    .tok           (tok),
    .event_sequence(evs)
  );

  assign bus.event_sequence = evs;
  assign bus.busy           = (state_q != StIdle) || (tok != '0);
  assign bus.done           = done_q;
  assign bus.seq_count      = seq_count_q;

endmodule

// File: tb/tb_ovl_cycle_sequence_gen.sv
// Bench for ovl_cycle_sequence_gen: a pipelined and a no-pipe instance share the same
// stimulus. Each is compared against a burst-level model that schedules issue times
// arithmetically and derives the event vector from each sequence's age.
module tb_ovl_cycle_sequence_gen;

  localparam int NC = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ovl_cycle_sequence_gen_if #(.NUM_CKS(NC), .CNT_W(CW)) bus_p ();
  ovl_cycle_sequence_gen_if #(.NUM_CKS(NC), .CNT_W(CW)) bus_n ();

  ovl_cycle_sequence_gen #(.NUM_CKS(NC), .CNT_W(CW), .PIPELINED(1'b1)) dut_p (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_p)
  );

  ovl_cycle_sequence_gen #(.NUM_CKS(NC), .CNT_W(CW), .PIPELINED(1'b0)) dut_n (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0 = pipelined instance, 1 = no-pipe instance.
  int k_act;            // count of unstalled clock edges since reset release
  bit m_have  [2];
  int m_t0    [2];
  int m_n     [2];
  int m_sp    [2];
  int m_fidx  [2];
  int m_stg   [2];
  int m_tdone [2];
  int m_base  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] exp_evs(input int d);
    logic [NC-1:0] v = '0;
    if (m_have[d]) begin
      for (int i = 0; i < m_n[d]; i++) begin
        int age = k_act - 1 - (m_t0[d] + i * m_sp[d]);
        if (age >= 0 && age < NC && !(i == m_fidx[d] && age == m_stg[d])) v[NC-1-age] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int d);
    int c = m_base[d];
    if (m_have[d] && k_act >= m_t0[d]) begin
      int iss = (k_act - m_t0[d]) / m_sp[d] + 1;
      if (iss > m_n[d]) iss = m_n[d];
      c += iss;
    end
    return CW'(c);
  endfunction

  task automatic model_clear();
    k_act = 0;
    for (int d = 0; d < 2; d++) begin
      m_have[d] = 1'b0;
      m_base[d] = 0;
      m_n[d]    = 0;
      m_t0[d]   = 0;
      m_sp[d]   = 1;
      m_tdone[d] = 0;
    end
  endtask

  task automatic set_inputs(input bit st, input int len, input int gp, input bit fe,
                            input int fs, input int fg, input bit sl);
    bus_p.start = st;  bus_p.burst_len = CW'(len); bus_p.gap = CW'(gp);
    bus_p.fault_en = fe; bus_p.fault_seq = CW'(fs); bus_p.fault_stage = 2'(fg);
    bus_p.stall = sl;
    bus_n.start = st;  bus_n.burst_len = CW'(len); bus_n.gap = CW'(gp);
    bus_n.fault_en = fe; bus_n.fault_seq = CW'(fs); bus_n.fault_stage = 2'(fg);
    bus_n.stall = sl;
  endtask

  // One clock: apply inputs, advance model at the edge, compare both DUTs 1 ns later.
  task automatic step(input bit st, input int len, input int gp, input bit fe,
                      input int fs, input int fg, input bit sl);
    set_inputs(st, len, gp, fe, fs, fg, sl);
    @(posedge clk);
    if (!sl) begin
      k_act++;
      for (int d = 0; d < 2; d++) begin
        if (st && (!m_have[d] || k_act > m_tdone[d])) begin
          int g1 = gp + 1;
          if (m_have[d]) m_base[d] += m_n[d];
          m_have[d]  = 1'b1;
          m_t0[d]    = k_act;
          m_n[d]     = (len == 0) ? 1 : len;
          m_sp[d]    = (d == 0) ? g1 : ((g1 > NC) ? g1 : NC);
          m_fidx[d]  = fe ? fs : -1;
          m_stg[d]   = fg;
          m_tdone[d] = m_t0[d] + (m_n[d] - 1) * m_sp[d] + NC + 1;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [NC-1:0] evs  = (d == 0) ? bus_p.event_sequence : bus_n.event_sequence;
      logic          bsy  = (d == 0) ? bus_p.busy : bus_n.busy;
      logic          dn   = (d == 0) ? bus_p.done : bus_n.done;
      logic [CW-1:0] cnt  = (d == 0) ? bus_p.seq_count : bus_n.seq_count;
      bit            e_bsy = m_have[d] && k_act >= m_t0[d] && k_act < m_tdone[d];
      bit            e_dn  = m_have[d] && k_act == m_tdone[d];
      check_eq($sformatf("evs%0d", d), 32'(evs), 32'(exp_evs(d)));
      check_eq($sformatf("busy%0d", d), 32'(bsy), 32'(e_bsy));
      check_eq($sformatf("done%0d", d), 32'(dn), 32'(e_dn));
      check_eq($sformatf("seqcnt%0d", d), 32'(cnt), 32'(exp_cnt(d)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1, 0, 1'b0, 0, 0, 1'b0);
  endtask

  logic [NC-1:0] tr1 [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
  logic [NC-1:0] tr2 [6] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
  logic [NC-1:0] tr3 [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
  logic [NC-1:0] tr4 [7] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b100, 3'b000, 3'b001};

  initial begin
    reset = 1'b1;
    set_inputs(1'b0, 1, 0, 1'b0, 0, 0, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_evs", 32'(bus_p.event_sequence), 32'h0);
    check_eq("rst_busy", 32'(bus_p.busy), 32'h0);
    check_eq("rst_done", 32'(bus_n.done), 32'h0);
    check_eq("rst_cnt", 32'(bus_n.seq_count), 32'h0);
    #1 reset = 1'b0;

    // Single sequence.
    step(1'b1, 1, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check_eq("single_evs", 32'(bus_p.event_sequence), 32'(tr1[i]));
    end
    check_eq("single_done", 32'(bus_p.done), 32'h1);
    check_eq("single_cnt", 32'(bus_p.seq_count), 32'h1);
    idle(2);

    // Back-to-back pipelined burst of 3.
    step(1'b1, 3, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check_eq("pipe3_evs", 32'(bus_p.event_sequence), 32'(tr2[i]));
    end
    check_eq("pipe3_done", 32'(bus_p.done), 32'h1);
    idle(8);

    // No-pipe burst of 2 with gap 0: starts NUM_CKS apart.
    step(1'b1, 2, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check_eq("nopipe_evs", 32'(bus_n.event_sequence), 32'(tr3[i]));
    end
    idle(6);

    // Fault on sequence 1, stage 1, gap 3.
    step(1'b1, 2, 3, 1'b1, 1, 1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      idle(1);
      check_eq("fault_evs", 32'(bus_p.event_sequence), 32'(tr4[i]));
    end
    idle(6);

    // Stall for 4 cycles mid-sequence.
    step(1'b1, 1, 0, 1'b0, 0, 0, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1, 0, 1'b0, 0, 0, 1'b1);
      check_eq("stall_hold", 32'(bus_p.event_sequence), 32'h4);
    end
    idle(1);
    check_eq("stall_resume", 32'(bus_p.event_sequence), 32'h2);
    idle(6);

    // Async reset while tok = 110.
    step(1'b1, 3, 0, 1'b0, 0, 0, 1'b0);
    idle(1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_evs", 32'(bus_p.event_sequence), 32'h0);
    check_eq("arst_busy", 32'(bus_p.busy), 32'h0);
    check_eq("arst_busy_n", 32'(bus_n.busy), 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_clear();
    step(1'b1, 1, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check_eq("post_rst_evs", 32'(bus_p.event_sequence), 32'(tr1[i]));
    end
    idle(3);

    // Randomised traffic, including mid-burst input changes and stalls.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, NC - 1)), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
